// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue scheduler: pair buffer, one-entry hold slot and a RAW scoreboard
// HAZARD_DEPTH issue cycles deep. Define ISSUE_STATS_EN to add saturating issue/stall counters.
module dual_issue_scheduler #(
    parameter int HAZARD_DEPTH = 3
`ifdef ISSUE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] instr0_in,
    input  logic [15:0] instr1_in,
    input  logic        out_ready,
    input  logic        flush,
    output logic        issue0_valid,
    output logic        issue1_valid,
    output logic [15:0] issue0,
    output logic [15:0] issue1,
    output logic        stall_o
`ifdef ISSUE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] single_cnt,
    output logic [STAT_W-1:0] dual_cnt
`endif
);

    function automatic logic is_nop(input logic [15:0] x);
        return x[15:12] == 4'd0;
    endfunction

    // rt only counts as a source for register-register forms
    function automatic logic reads(input logic [15:0] x, input logic [2:0] r);
        return !is_nop(x) && ((x[7:5] == r) || (!x[11] && (x[4:2] == r)));
    endfunction

`ifdef ISSUE_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
`endif

    logic                    pb_valid;
    logic [15:0]             pb0;
    logic [15:0]             pb1;
    logic                    hold_valid;
    logic [15:0]             hold;
    logic [HAZARD_DEPTH-1:0] sb_v0;
    logic [HAZARD_DEPTH-1:0] sb_v1;
    logic [2:0]              sb_rd0 [HAZARD_DEPTH];
    logic [2:0]              sb_rd1 [HAZARD_DEPTH];

    logic [15:0] c0, c1, lane0;
    logic        c0_present, c1_present, nop0, nop1;
    logic        haz0, haz1, intra;
    logic        iss0, iss1, cons0;
    logic        lane0_v, lane1_v;
    logic        to_hold, stall_nxt, accept, sb_shift;

    always_comb begin
        c0         = hold_valid ? hold : pb0;
        c1         = pb1;
        c0_present = hold_valid | pb_valid;
        c1_present = !hold_valid & pb_valid;
        nop0       = is_nop(c0);
        nop1       = is_nop(c1);
        haz0       = 1'b0;
        haz1       = 1'b0;
        for (int i = 0; i < HAZARD_DEPTH; i++) begin
            if (sb_v0[i] && reads(c0, sb_rd0[i])) haz0 = 1'b1;
            if (sb_v1[i] && reads(c0, sb_rd1[i])) haz0 = 1'b1;
            if (sb_v0[i] && reads(c1, sb_rd0[i])) haz1 = 1'b1;
            if (sb_v1[i] && reads(c1, sb_rd1[i])) haz1 = 1'b1;
        end
        intra = !nop0 && (reads(c1, c0[10:8]) || (!nop1 && (c1[10:8] == c0[10:8])));
        iss0  = c0_present & !nop0 & !haz0;
        cons0 = c0_present & (nop0 | iss0);
        iss1  = c1_present & cons0 & !nop1 & !haz1 & !intra;
        // Issued instructions pack into lane 0 first, so a consumed NOP frees its lane
        lane0_v   = iss0 | iss1;
        lane1_v   = iss0 & iss1;
        lane0     = iss0 ? c0 : c1;
        to_hold   = c1_present & cons0 & !iss1 & !nop1;
        stall_nxt = !iss0 & !iss1 & ((c0_present & !nop0) | (c1_present & !nop1));
        in_ready  = out_ready & !rst & !flush & (!pb_valid | (!hold_valid & cons0));
        accept    = in_valid & in_ready;
        sb_shift  = flush | out_ready;
    end

    // issue stage: control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_valid     <= 1'b0;
            hold_valid   <= 1'b0;
            issue0_valid <= 1'b0;
            issue1_valid <= 1'b0;
            issue0       <= 16'h0;
            issue1       <= 16'h0;
            stall_o      <= 1'b0;
            sb_v0        <= '0;
            sb_v1        <= '0;
        end else if (flush) begin
            pb_valid     <= 1'b0;
            hold_valid   <= 1'b0;
            issue0_valid <= 1'b0;
            issue1_valid <= 1'b0;
            issue0       <= 16'h0;
            issue1       <= 16'h0;
            stall_o      <= 1'b0;
            // in-flight producers still write back, so age them out with bubbles
            for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                sb_v0[i] <= sb_v0[i-1];
                sb_v1[i] <= sb_v1[i-1];
            end
            sb_v0[0] <= 1'b0;
            sb_v1[0] <= 1'b0;
        end else if (out_ready) begin
            issue0_valid <= lane0_v;
            issue1_valid <= lane1_v;
            issue0       <= lane0_v ? lane0 : 16'h0;
            issue1       <= lane1_v ? c1 : 16'h0;
            stall_o      <= stall_nxt;
            if (to_hold) hold_valid <= 1'b1;
            else if (hold_valid && cons0) hold_valid <= 1'b0;
            if (accept) pb_valid <= 1'b1;
            else if (cons0 && !hold_valid) pb_valid <= 1'b0;
            for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                sb_v0[i] <= sb_v0[i-1];
                sb_v1[i] <= sb_v1[i-1];
            end
            sb_v0[0] <= lane0_v;
            sb_v1[0] <= lane1_v;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pb0 <= instr0_in;
            pb1 <= instr1_in;
        end
        if (out_ready && !flush && to_hold) hold <= pb1;
        if (sb_shift) begin
            for (int i = HAZARD_DEPTH - 1; i > 0; i--) begin
                sb_rd0[i] <= sb_rd0[i-1];
                sb_rd1[i] <= sb_rd1[i-1];
            end
            sb_rd0[0] <= lane0[10:8];
            sb_rd1[0] <= c1[10:8];
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            single_cnt <= '0;
            dual_cnt   <= '0;
        end else if (out_ready && !flush) begin
            if (stall_nxt) stall_cnt <= sat_inc(stall_cnt);
            if (lane0_v && !lane1_v) single_cnt <= sat_inc(single_cnt);
            if (lane1_v) dual_cnt <= sat_inc(dual_cnt);
        end
    end
`endif

endmodule
